dsram_responder: RTL and testbench

DSRAM_RESPONDER -- requirements
Module: dsram_responder

---
 rtl/dsram_responder.sv | 150 +++++++++++++++
 tb/tb_dsram_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_responder.sv
// Single-port word SRAM responder: requests queue up, each gets one data_ok LATENCY cycles after service starts, served in order.
// Backpressure: data_addr_ok low while the queue is full; with DSRAM_RANDOM_STALL_EN an LFSR also stalls acceptance at random.
module dsram_responder #(
  parameter int ADDR_W     = 10,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);
  localparam int         AW     = ADDR_W + 2;
  localparam int         PTR_W  = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int         WORDS  = 1 << ADDR_W;
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);
  localparam logic [2:0] DEPTH  = 3'(FIFO_DEPTH);

  typedef struct packed {
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  req_t              q_mem_q [FIFO_DEPTH];
  logic [31:0]       mem_q [WORDS];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]        count_q, count_d;
  logic [2:0]        cnt_q, cnt_d;
  state_t            state_q, state_d;
  req_t              cur_q, cur_d;
  req_t              in_req;
  logic              room, push, pop, commit;
  logic [3:0]        strb;
  logic [ADDR_W-1:0] cur_idx;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^data_addr[31:AW];
  assign in_req = '{wr: data_wr, size: data_size, addr: data_addr[AW-1:0], wdata: data_wdata};

`ifdef DSRAM_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign room = (count_q < DEPTH) && !lfsr_q[0];
`else
  assign room = count_q < DEPTH;
`endif

  assign data_addr_ok = room;
  assign push         = data_req && room;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          cur_d   = q_mem_q[rd_ptr_q];
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      count_q  <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cur_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cur_q    <= cur_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem_q[wr_ptr_q] <= in_req;
  end

  // Halfword ignores addr[0]; word ignores addr[1:0]
  always_comb begin
    strb = 4'b1111;
    case (cur_q.size)
      2'd0:    strb = 4'b0001 << cur_q.addr[1:0];
      2'd1:    strb = cur_q.addr[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  assign cur_idx      = cur_q.addr[AW-1:2];
  assign data_data_ok = (state_q == RESP);
  assign commit       = data_data_ok && cur_q.wr;
  assign data_rdata   = (data_data_ok && !cur_q.wr) ? mem_q[cur_idx] : 32'h0;

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem_q[cur_idx][8*b +: 8] <= cur_q.wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dsram_responder.sv
// Self-checking bench for dsram_responder: directed vector table, hand-written corner sequences, random traffic vs a reference memory.
module tb_dsram_responder;
  localparam int LAT   = 2;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  dsram_responder #(.ADDR_W(10), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    logic        chk_lat;
    int          acc_cyc;
  } sb_t;

  sb_t         sb[$];
  vec_t        tv[17];
  vec_t        bv[6];
  logic [31:0] ref_mem[16];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_resp = 0;
  int          low_seen = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] sz,
                                        input logic [1:0] lo, input logic [31:0] wd);
    logic [31:0] m;
    case (sz)
      2'd0:    m = 32'hFF << (8 * lo);
      2'd1:    m = lo[1] ? 32'hFFFF0000 : 32'h0000FFFF;
      default: m = 32'hFFFFFFFF;
    endcase
    return (old & ~m) | (wd & m);
  endfunction

  // Response monitor: pops the scoreboard on every data_ok pulse
  always @(negedge clk) begin : mon
    sb_t e;
    if (!rst) begin
      if (data_data_ok) begin
        n_resp++;
        if (sb.size() == 0) begin
          check("unexpected_data_ok", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rdata", data_rdata, e.exp);
          if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
        end
      end else begin
        check("rdata_zero_when_idle", data_rdata, 32'h0);
      end
    end
  end

  // Called at negedge+1; returns at negedge+1 after the accepting edge with data_req still high
  task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp, input logic chk);
    int  w;
    sb_t e;
    w = 0;
    data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = addr; data_wdata = wd;
    while (!data_addr_ok && w < 100) begin
      low_seen++;
      @(negedge clk); #1;
      w++;
    end
    if (!data_addr_ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.exp = exp; e.chk_lat = chk; e.acc_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk); #1;
  endtask

  task automatic idle();
    data_req = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk); #1;
      w++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stall, w, n0;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a, wd, exp;

    tv[0]  = '{1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0};
    tv[1]  = '{1'b0, 2'd2, 32'h10, 32'h0,        32'hDEADBEEF};
    tv[2]  = '{1'b1, 2'd2, 32'h20, 32'h11223344, 32'h0};
    tv[3]  = '{1'b1, 2'd0, 32'h22, 32'hAAAAAAAA, 32'h0};
    tv[4]  = '{1'b0, 2'd2, 32'h20, 32'h0,        32'h11AA3344};
    tv[5]  = '{1'b1, 2'd1, 32'h23, 32'h55665566, 32'h0};
    tv[6]  = '{1'b0, 2'd2, 32'h20, 32'h0,        32'h55663344};
    tv[7]  = '{1'b1, 2'd2, 32'h30, 32'h0,        32'h0};
    tv[8]  = '{1'b1, 2'd0, 32'h31, 32'h12121212, 32'h0};
    tv[9]  = '{1'b1, 2'd0, 32'h33, 32'h77777777, 32'h0};
    tv[10] = '{1'b0, 2'd0, 32'h30, 32'h0,        32'h77001200};
    tv[11] = '{1'b1, 2'd1, 32'h31, 32'hBEEFBEEF, 32'h0};
    tv[12] = '{1'b0, 2'd1, 32'h32, 32'h0,        32'h7700BEEF};
    tv[13] = '{1'b1, 2'd3, 32'h33, 32'hCAFEF00D, 32'h0};
    tv[14] = '{1'b0, 2'd2, 32'h30, 32'h0,        32'hCAFEF00D};
    tv[15] = '{1'b1, 2'd0, 32'h10, 32'h99999999, 32'h0};
    tv[16] = '{1'b0, 2'd2, 32'h10, 32'h0,        32'hDEADBE99};

    bv[0] = '{1'b1, 2'd2, 32'h60, 32'hA0A0A0A0, 32'h0};
    bv[1] = '{1'b0, 2'd2, 32'h60, 32'h0,        32'hA0A0A0A0};
    bv[2] = '{1'b1, 2'd2, 32'h64, 32'hB1B1B1B1, 32'h0};
    bv[3] = '{1'b0, 2'd2, 32'h64, 32'h0,        32'hB1B1B1B1};
    bv[4] = '{1'b1, 2'd0, 32'h61, 32'h5C5C5C5C, 32'h0};
    bv[5] = '{1'b0, 2'd2, 32'h60, 32'h0,        32'hA0A05CA0};

    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_data_ok", 32'(data_data_ok), 32'd0);
    check("rst_rdata", data_rdata, 32'h0);
    rst = 1'b0;
`ifndef DSRAM_RANDOM_STALL_EN
    check("rst_addr_ok", 32'(data_addr_ok), 32'd1);
`endif

    stall = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (!data_addr_ok) stall++;
    end
`ifdef DSRAM_RANDOM_STALL_EN
    check("stall_seen_queue_empty", 32'(stall > 0), 32'd1);
`else
    check("no_stall_queue_empty", 32'(stall), 32'd0);
`endif

    for (int i = 0; i < 17; i++) begin
      send(tv[i].wr, tv[i].size, tv[i].addr, tv[i].wdata, tv[i].exp, 1'b1);
      idle();
      wait_drain();
    end

    // Read queued behind a same-address write
    send(1'b1, 2'd2, 32'h40, 32'h5, 32'h0, 1'b1);
    send(1'b0, 2'd2, 32'h40, 32'h0, 32'h5, 1'b0);
    idle();
    wait_drain();

    // Back-to-back burst against a full queue
    low_seen = 0;
    n0 = n_resp;
    for (int i = 0; i < 6; i++) send(bv[i].wr, bv[i].size, bv[i].addr, bv[i].wdata, bv[i].exp, 1'b0);
    idle();
    wait_drain();
    check("burst_resp_count", 32'(n_resp - n0), 32'd6);
    check("burst_addr_ok_dropped", 32'(low_seen > 0), 32'd1);

    // Asynchronous reset during a read response
    send(1'b0, 2'd2, 32'h10, 32'h0, 32'hDEADBE99, 1'b1);
    idle();
    w = 0;
    while (!data_data_ok && w < 50) begin
      @(negedge clk); #1;
      w++;
    end
    check("resp_seen_before_rst", 32'(data_data_ok), 32'd1);
    sb.delete();
    rst = 1'b1;
    #1;
    check("async_rst_data_ok", 32'(data_data_ok), 32'd0);
    check("async_rst_rdata", data_rdata, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;

    // Reset while a write is in WAIT with another queued behind it
    send(1'b1, 2'd2, 32'h50, 32'h0BADF00D, 32'h0, 1'b1);
    idle();
    wait_drain();
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h50; data_wdata = 32'hFFFFFFFF;
    @(negedge clk); #1;
    data_size = 2'd0; data_wdata = 32'h12345678;
    @(negedge clk); #1;
    data_req = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_in_wait_data_ok", 32'(data_data_ok), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
`ifndef DSRAM_RANDOM_STALL_EN
    check("addr_ok_after_release", 32'(data_addr_ok), 32'd1);
`endif
    repeat (6) begin
      @(negedge clk); #1;
    end
    send(1'b0, 2'd2, 32'h50, 32'h0, 32'h0BADF00D, 1'b1);
    idle();
    wait_drain();

    // Random traffic against the reference memory
    for (int i = 0; i < 16; i++) begin
      wd = $urandom();
      ref_mem[i] = wd;
      send(1'b1, 2'd2, 32'h200 + 32'(4 * i), wd, 32'h0, 1'b0);
    end
    for (int n = 0; n < 1000; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'h200 + 32'($urandom_range(0, 63));
      wd = $urandom();
      if (wr) begin
        exp = 32'h0;
        ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], sz, a[1:0], wd);
      end else begin
        exp = ref_mem[a[5:2]];
      end
      send(wr, sz, a, wd, exp, 1'b0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
